mem_arbiter: RTL and testbench

- Sequencer/arbiter that shares one single-port, synchronous-read word memory between the instruction-fetch port and the data load/store port.
- Supports LW, SW and an atomic swap (SWAPRM): read the old word, then write the new word, with no other access in between.
- Sits between the processor core and the unified memory array.

---
 rtl/mem_arb_pkg.sv | 37 +++
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter_rr_arb2.sv | 46 ++++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the fetch/data memory arbiter.
// Included by the interface, the round-robin picker and the arbiter top.
package mem_arb_pkg;

  localparam int AW = 6;
  localparam int DW = 32;

  typedef enum logic [1:0] {
    OP_LW   = 2'b00,
    OP_SW   = 2'b01,
    OP_SWAP = 2'b10,
    OP_RSVD = 2'b11
  } d_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RESP   = 3'd2,
    ST_WR     = 3'd3,
    ST_SWP_WR = 3'd4
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_e;

  // Reserved encodings fall through to a plain load.
  function automatic logic is_store(input d_op_e op);
    return (op == OP_SW);
  endfunction

  function automatic logic is_swap(input d_op_e op);
    return (op == OP_SWAP);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/response buses plus the memory-side bus of the arbiter.
// The arbiter uses the slave view; the core/memory environment uses master.
interface mem_arbiter_if #(
  parameter int AW = mem_arb_pkg::AW,
  parameter int DW = mem_arb_pkg::DW
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic [1:0]    d_op;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  if_req, if_addr, d_req, d_op, d_addr, d_wdata, mem_rd,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_addr, mem_we, mem_wd
  );

  modport master (
    output if_req, if_addr, d_req, d_op, d_addr, d_wdata, mem_rd,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_addr, mem_we, mem_wd
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker; on a tie the requester that did not win last
// time is chosen. The history starts at DATA so fetch wins the first tie.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic req_if_i,
  input  logic req_d_i,
  output logic gnt_if_o,
  output logic gnt_d_o
);

  req_e last_q;

  always_comb begin
    gnt_if_o = 1'b0;
    gnt_d_o  = 1'b0;
    if (en_i) begin
      if (req_if_i && req_d_i) begin
        gnt_if_o = (last_q == REQ_D);
        gnt_d_o  = (last_q == REQ_IF);
      end else begin
        gnt_if_o = req_if_i;
        gnt_d_o  = req_d_i;
      end
    end else begin
      gnt_if_o = 1'b0;
      gnt_d_o  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= REQ_D;
    end else if (gnt_if_o) begin
      last_q <= REQ_IF;
    end else if (gnt_d_o) begin
      last_q <= REQ_D;
    end else begin
      last_q <= last_q;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory between instruction fetch and the data
// port (LW / SW / atomic SWAP). Grants are only issued from IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  state_e        state_q;
  req_e          who_q;
  logic          swap_q;
  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic [DW-1:0] mem_wd_q;
  logic          if_valid_q;
  logic          d_valid_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;

  logic  gnt_if_s;
  logic  gnt_d_s;
  logic  d_live_s;
  d_op_e op_s;

  assign op_s = d_op_e'(bus.d_op);

  rr_arb2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .en_i     (state_q == ST_IDLE),
    .req_if_i (bus.if_req),
    .req_d_i  (bus.d_req),
    .gnt_if_o (gnt_if_s),
    .gnt_d_o  (gnt_d_s)
  );

  // Read data arrives straight from the memory in the valid cycle; a SW pulse
  // on d_valid must not disturb the held load data.
  assign d_live_s = d_valid_q && ((state_q == ST_RESP) || (state_q == ST_SWP_WR));

  assign bus.if_gnt   = gnt_if_s;
  assign bus.d_gnt    = gnt_d_s;
  assign bus.if_valid = if_valid_q;
  assign bus.d_valid  = d_valid_q;
  assign bus.if_rdata = if_valid_q ? bus.mem_rd : if_rdata_q;
  assign bus.d_rdata  = d_live_s ? bus.mem_rd : d_rdata_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_wd   = mem_wd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      who_q      <= REQ_IF;
      swap_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_wd_q   <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_if_s) begin
            who_q      <= REQ_IF;
            swap_q     <= 1'b0;
            mem_addr_q <= bus.if_addr;
            state_q    <= ST_RD;
          end else if (gnt_d_s) begin
            who_q      <= REQ_D;
            swap_q     <= is_swap(op_s);
            mem_addr_q <= bus.d_addr;
            mem_wd_q   <= bus.d_wdata;
            if (is_store(op_s)) begin
              mem_we_q  <= 1'b1;
              d_valid_q <= 1'b1;
              state_q   <= ST_WR;
            end else begin
              state_q   <= ST_RD;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RD: begin
          // Swap goes straight to its write; nothing can be granted in between.
          if (swap_q) begin
            mem_we_q  <= 1'b1;
            d_valid_q <= 1'b1;
            state_q   <= ST_SWP_WR;
          end else if (who_q == REQ_IF) begin
            if_valid_q <= 1'b1;
            state_q    <= ST_RESP;
          end else begin
            d_valid_q <= 1'b1;
            state_q   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (if_valid_q) begin
            if_rdata_q <= bus.mem_rd;
          end else begin
            d_rdata_q <= bus.mem_rd;
          end
          state_q <= ST_IDLE;
        end
        ST_SWP_WR: begin
          d_rdata_q <= bus.mem_rd;
          state_q   <= ST_IDLE;
        end
        ST_WR: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions plus
// hand-written sequences for swap atomicity, round-robin and mid-op reset.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: synchronous read-before-write, plus a bench back-door write.
  logic [31:0] tbmem [0:63];
  logic        poke_en;
  logic [5:0]  poke_addr;
  logic [31:0] poke_data;

  always @(posedge clk) begin
    bus.mem_rd <= tbmem[bus.mem_addr];
    if (poke_en) tbmem[poke_addr] <= poke_data;
    else if (bus.mem_we) tbmem[bus.mem_addr] <= bus.mem_wd;
  end

  typedef struct {
    string       name;
    logic        is_d;
    logic [1:0]  op;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic poke(input logic [5:0] a, input logic [31:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    @(posedge clk); #1;
    poke_en   = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_mem_addr"}, {26'd0, bus.mem_addr}, 32'd0);
    chk({nm, "_mem_we"},   {31'd0, bus.mem_we},   32'd0);
    chk({nm, "_mem_wd"},   bus.mem_wd,            32'd0);
    chk({nm, "_if_valid"}, {31'd0, bus.if_valid}, 32'd0);
    chk({nm, "_d_valid"},  {31'd0, bus.d_valid},  32'd0);
    chk({nm, "_if_rdata"}, bus.if_rdata,          32'd0);
    chk({nm, "_d_rdata"},  bus.d_rdata,           32'd0);
  endtask

  // Entered and left at posedge+1 of an IDLE cycle.
  task automatic run_vec(input vec_t v);
    int   w;
    logic got;
    logic st;
    logic sw;
    st = v.is_d && (v.op == 2'b01);
    sw = v.is_d && (v.op == 2'b10);
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_op = v.op; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end
    #1;
    w = 0;
    got = v.is_d ? bus.d_gnt : bus.if_gnt;
    while (!got && w < 8) begin
      @(posedge clk); #2;
      got = v.is_d ? bus.d_gnt : bus.if_gnt;
      w++;
    end
    chk({v.name, "_gnt"}, {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    bus.d_op   = 2'b01;
    chk({v.name, "_c1_addr"}, {26'd0, bus.mem_addr}, {26'd0, v.addr});
    chk({v.name, "_c1_we"}, {31'd0, bus.mem_we}, {31'd0, st});
    if (st) begin
      chk({v.name, "_c1_wd"}, bus.mem_wd, v.wdata);
      chk({v.name, "_c1_dvalid"}, {31'd0, bus.d_valid}, 32'd1);
      @(posedge clk); #1;
      chk({v.name, "_c2_dvalid"}, {31'd0, bus.d_valid}, 32'd0);
      chk({v.name, "_c2_we"}, {31'd0, bus.mem_we}, 32'd0);
    end else begin
      chk({v.name, "_c1_valid"}, {31'd0, (bus.if_valid | bus.d_valid)}, 32'd0);
      @(posedge clk); #1;
      chk({v.name, "_c2_valid"}, {31'd0, (v.is_d ? bus.d_valid : bus.if_valid)}, 32'd1);
      chk({v.name, "_c2_rdata"}, (v.is_d ? bus.d_rdata : bus.if_rdata), v.exp_rdata);
      chk({v.name, "_c2_we"}, {31'd0, bus.mem_we}, {31'd0, sw});
      @(posedge clk); #1;
      chk({v.name, "_c3_valid"}, {31'd0, (bus.if_valid | bus.d_valid)}, 32'd0);
      chk({v.name, "_c3_hold"}, (v.is_d ? bus.d_rdata : bus.if_rdata), v.exp_rdata);
      chk({v.name, "_c3_we"}, {31'd0, bus.mem_we}, 32'd0);
    end
  endtask

  initial begin
    int w;
    vecs[0] = '{"fetch3",  1'b0, 2'b00, 6'd3,  32'h0,        32'h8fa80000};
    vecs[1] = '{"sw5",     1'b1, 2'b01, 6'd5,  32'h00000006, 32'h0};
    vecs[2] = '{"lw5",     1'b1, 2'b00, 6'd5,  32'h0,        32'h00000006};
    vecs[3] = '{"rsvd2",   1'b1, 2'b11, 6'd2,  32'h12345678, 32'h20080005};
    vecs[4] = '{"fetch10", 1'b0, 2'b00, 6'd10, 32'h0,        32'hdeadbeef};
    vecs[5] = '{"lw63",    1'b1, 2'b00, 6'd63, 32'h0,        32'hcafef00d};
    vecs[6] = '{"sw0",     1'b1, 2'b01, 6'd0,  32'hffffffff, 32'h0};
    vecs[7] = '{"fetch0",  1'b0, 2'b00, 6'd0,  32'h0,        32'hffffffff};

    reset = 1'b1;
    poke_en = 1'b0; poke_addr = 6'd0; poke_data = 32'd0;
    bus.if_req = 1'b0; bus.if_addr = 6'd0;
    bus.d_req = 1'b0; bus.d_op = 2'b00; bus.d_addr = 6'd0; bus.d_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    poke(6'd3,  32'h8fa80000);
    poke(6'd2,  32'h20080005);
    poke(6'd7,  32'h00000005);
    poke(6'd10, 32'hdeadbeef);
    poke(6'd63, 32'hcafef00d);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Swap on word 7 while fetch waits: fetch only granted once back in IDLE.
    bus.d_req = 1'b1; bus.d_op = 2'b10; bus.d_addr = 6'd7; bus.d_wdata = 32'd6;
    #1;
    chk("swap_gnt", {31'd0, bus.d_gnt}, 32'd1);
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.d_op = 2'b00;
    bus.if_req = 1'b1; bus.if_addr = 6'd3;
    #1;
    chk("swap_c1_ifgnt", {31'd0, bus.if_gnt}, 32'd0);
    chk("swap_c1_we", {31'd0, bus.mem_we}, 32'd0);
    chk("swap_c1_addr", {26'd0, bus.mem_addr}, 32'd7);
    @(posedge clk); #2;
    chk("swap_c2_ifgnt", {31'd0, bus.if_gnt}, 32'd0);
    chk("swap_c2_dvalid", {31'd0, bus.d_valid}, 32'd1);
    chk("swap_c2_rdata", bus.d_rdata, 32'd5);
    chk("swap_c2_we", {31'd0, bus.mem_we}, 32'd1);
    chk("swap_c2_wd", bus.mem_wd, 32'd6);
    @(posedge clk); #2;
    chk("swap_c3_ifgnt", {31'd0, bus.if_gnt}, 32'd1);
    chk("swap_c3_dvalid", {31'd0, bus.d_valid}, 32'd0);
    chk("swap_c3_hold", bus.d_rdata, 32'd5);
    chk("swap_word7", tbmem[7], 32'd6);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    @(posedge clk); #1;
    chk("swap_fetch_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("swap_fetch_rdata", bus.if_rdata, 32'h8fa80000);
    @(posedge clk); #1;
    run_vec('{"lw7", 1'b1, 2'b00, 6'd7, 32'h0, 32'h00000006});

    // Both ports held from reset: grants must alternate IF, D, IF, D.
    reset = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 6'd3;
    bus.d_req = 1'b1; bus.d_op = 2'b00; bus.d_addr = 6'd2;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    for (int n = 0; n < 4; n++) begin
      w = 0;
      while (!(bus.if_gnt || bus.d_gnt) && w < 6) begin
        @(posedge clk); #2;
        w++;
      end
      chk("rr_any", {31'd0, (bus.if_gnt | bus.d_gnt)}, 32'd1);
      chk("rr_both", {31'd0, (bus.if_gnt & bus.d_gnt)}, 32'd0);
      chk("rr_order", {31'd0, bus.d_gnt}, {31'd0, n[0]});
      @(posedge clk); #2;
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset while a swap of word 7 sits in RD: memory untouched, fetch first after.
    poke(6'd7, 32'd5);
    bus.d_req = 1'b1; bus.d_op = 2'b10; bus.d_addr = 6'd7; bus.d_wdata = 32'd9;
    #1;
    chk("rst_swap_gnt", {31'd0, bus.d_gnt}, 32'd1);
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 6'd10;
    reset = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    @(posedge clk); #1;
    chk("rst_no_dvalid", {31'd0, bus.d_valid}, 32'd0);
    chk("rst_no_we", {31'd0, bus.mem_we}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_if_first", {31'd0, bus.if_gnt}, 32'd1);
    chk("rst_d_waits", {31'd0, bus.d_gnt}, 32'd0);
    chk("rst_word7", tbmem[7], 32'd5);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    #1;
    w = 0;
    while (!bus.d_gnt && w < 6) begin
      @(posedge clk); #2;
      w++;
    end
    chk("rst_d_next", {31'd0, bus.d_gnt}, 32'd1);
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.d_op = 2'b00;
    @(posedge clk); #1;
    chk("rst_swap_valid", {31'd0, bus.d_valid}, 32'd1);
    chk("rst_swap_old", bus.d_rdata, 32'd5);
    @(posedge clk); #1;
    chk("rst_swap_word7", tbmem[7], 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
